// File: rtl/fu_mul_pkg.sv
// Shared definitions for the pipelined multiply unit: op encodings,
// default geometry and small decode helpers used by the issue stage.
package fu_mul_pkg;

  // Op encodings carried on the 2-bit op port.
  localparam logic [1:0] OP_MUL    = 2'b00;  // low half, sign-agnostic
  localparam logic [1:0] OP_MULH   = 2'b01;  // high half, signed x signed
  localparam logic [1:0] OP_MULHSU = 2'b10;  // high half, signed x unsigned
  localparam logic [1:0] OP_MULHU  = 2'b11;  // high half, unsigned x unsigned

  // Default geometry of the unit.
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_LATENCY = 7;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == OP_MULH);
  endfunction

  // MUL returns the low half; every other mode returns the high half.
  function automatic logic op_takes_low(input logic [1:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/mul_core.sv
// Signed (WIDTH+1)x(WIDTH+1) multiplier with STAGES register stages.
// Operands arrive already sign- or zero-extended by one bit, so a single
// signed multiplier covers all four op modes. The product is registered
// straight off the multiplier and then delayed; downstream synthesis
// retiming is expected to spread the multiplier across the delay stages.
// All stages share one enable so the whole pipe freezes as a unit.
module mul_core #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 6
) (
  input  logic                 clk,
  input  logic                 i_en,
  input  logic signed [WIDTH:0] i_a,
  input  logic signed [WIDTH:0] i_b,
  output logic [2*WIDTH-1:0]   o_p
);

  // Full-width signed product; the two extra top bits are pure sign
  // extension once the operands are at most WIDTH+1 bits, so only the
  // low 2*WIDTH bits carry information.
  logic signed [2*WIDTH+1:0] w_full;
  logic [1:0]                w_unused_hi;

  assign w_full      = i_a * i_b;
  assign w_unused_hi = w_full[2*WIDTH+1:2*WIDTH];

  // Product data pipeline; data registers need no reset because the
  // valid bits in the parent decide whether anything here is consumed.
  logic [2*WIDTH-1:0] r_stage [STAGES];

  // First stage captures the multiplier output.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_stage[0] <= w_full[2*WIDTH-1:0];
    end
  end

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_delay
      // Later stages shift the product forward when the pipe advances.
      always_ff @(posedge clk) begin
        if (i_en) begin
          r_stage[gi] <= r_stage[gi-1];
        end
      end
    end
  endgenerate

  assign o_p = r_stage[STAGES-1];

endmodule

// File: rtl/fu_mul_pipe.sv
// Fully pipelined multiply functional unit. Accepts one op per cycle and
// returns results in issue order LATENCY cycles later. A consumer
// backpressures through res_ack; while a result is presented but not
// acknowledged the entire pipe freezes. flush drops everything in flight.
// Stage map: LATENCY-1 stages inside mul_core (valid/tag/op shadowed here)
// followed by the output register holding res/tag_out/finish.
module fu_mul_pipe
  import fu_mul_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,  // legal range 2..16
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  input  logic             res_ack,
  output logic             ready,
  output logic             finish,
  output logic [WIDTH-1:0] res,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CORE_STAGES = LATENCY - 1;

  // Pipeline control: a presented but unacknowledged result stalls
  // everything; otherwise every stage moves forward one step per edge.
  logic w_stall;
  logic w_adv;

  // Valid bits, one per stage; the top bit is the output stage (finish).
  logic [LATENCY-1:0] r_valid;

  // Tag and op shadows for the stages inside mul_core.
  logic [TAG_W-1:0] r_tag [CORE_STAGES];
  logic [1:0]       r_op  [CORE_STAGES];

  // Output stage registers.
  logic [WIDTH-1:0] r_res;
  logic [TAG_W-1:0] r_tag_out;

  // Operand extension and core product.
  logic                 w_a_sext;
  logic                 w_b_sext;
  logic signed [WIDTH:0] w_a_ext;
  logic signed [WIDTH:0] w_b_ext;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_res_sel;
  logic                 w_core_last_valid;

  assign w_stall = r_valid[LATENCY-1] & ~res_ack;
  assign w_adv   = ~w_stall;

  // One extra bit per operand: a copy of the MSB for signed treatment,
  // zero for unsigned treatment. A single signed multiply then yields the
  // correct 2*WIDTH product for every mode.
  assign w_a_sext = op_a_signed(op) & A[WIDTH-1];
  assign w_b_sext = op_b_signed(op) & B[WIDTH-1];
  assign w_a_ext  = {w_a_sext, A};
  assign w_b_ext  = {w_b_sext, B};

  mul_core #(
    .WIDTH  (WIDTH),
    .STAGES (CORE_STAGES)
  ) u_core (
    .clk  (clk),
    .i_en (w_adv),
    .i_a  (w_a_ext),
    .i_b  (w_b_ext),
    .o_p  (w_prod)
  );

  // Half-select driven by the op that travelled alongside the product.
  assign w_res_sel = op_takes_low(r_op[CORE_STAGES-1]) ? w_prod[WIDTH-1:0]
                                                       : w_prod[2*WIDTH-1:WIDTH];
  assign w_core_last_valid = r_valid[LATENCY-2];

  // Valid shift register; reset beats flush, flush beats stall, and an op
  // presented together with flush is dropped along with everything else.
  // While stalled, EN is not sampled because the shift does not happen.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid <= {r_valid[LATENCY-2:0], EN};
    end
  end

  // Issue stage captures the tag and op of the incoming request.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_tag[0] <= tag_in;
      r_op[0]  <= op;
    end
  end

  generate
    for (genvar gi = 1; gi < CORE_STAGES; gi++) begin : g_shadow
      // Tag/op shadows move in lockstep with the product stages.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_tag[gi] <= r_tag[gi-1];
          r_op[gi]  <= r_op[gi-1];
        end
      end
    end
  endgenerate

  // Output stage: loads only when a valid op moves in, so bubbles and
  // flushed slots leave the last presented res/tag_out untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res     <= '0;
      r_tag_out <= '0;
    end else if (w_adv && !flush && w_core_last_valid) begin
      r_res     <= w_res_sel;
      r_tag_out <= r_tag[CORE_STAGES-1];
    end
  end

  assign ready   = ~w_stall;
  assign finish  = r_valid[LATENCY-1];
  assign res     = r_res;
  assign tag_out = r_tag_out;

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Directed bench for fu_mul_pipe at WIDTH=32, LATENCY=7, TAG_W=4.
module tb_fu_mul_pipe;

  localparam int W = 32;
  localparam int L = 7;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         EN;
  logic [1:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [T-1:0] tag_in;
  logic         flush;
  logic         res_ack;
  logic         ready;
  logic         finish;
  logic [W-1:0] res;
  logic [T-1:0] tag_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fu_mul_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(T)) dut (
    .clk     (clk),
    .rst     (rst),
    .EN      (EN),
    .op      (op),
    .A       (A),
    .B       (B),
    .tag_in  (tag_in),
    .flush   (flush),
    .res_ack (res_ack),
    .ready   (ready),
    .finish  (finish),
    .res     (res),
    .tag_out (tag_out)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] t);
    EN = 1'b1; op = o; A = a; B = b; tag_in = t;
    step();
    EN = 1'b0;
  endtask

  // Issue one op, wait (bounded) for finish, check latency/res/tag, let it retire.
  task automatic run_one(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [T-1:0] t, input logic [W-1:0] exp);
    int cnt;
    issue(o, a, b, t);
    cnt = 1;
    while (finish !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    $display("[TB] %s op=%0d A=%h B=%h tag=%0d -> res=%h tag_out=%0d after %0d cycles",
             name, o, a, b, t, res, tag_out, cnt);
    chk({name, "_lat"}, 64'(cnt), 64'(L));
    chk({name, "_res"}, 64'(res), 64'(exp));
    chk({name, "_tag"}, 64'(tag_out), 64'(t));
    step();
  endtask

  initial begin
    int nfin;
    rst = 1'b1; EN = 1'b0; op = 2'b00; A = '0; B = '0; tag_in = '0;
    flush = 1'b0; res_ack = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_finish", 64'(finish), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_tag", 64'(tag_out), 64'(0));
    chk("rst_ready", 64'(ready), 64'(1));

    // Basic MUL with exact latency edge: finish low after 6 edges, high after 7
    issue(2'b00, 32'h0000_0007, 32'h0000_0006, 4'd3);
    repeat (5) step();
    chk("mul7x6_early", 64'(finish), 64'(0));
    step();
    $display("[TB] mul7x6 res=%h tag_out=%0d finish=%0d", res, tag_out, finish);
    chk("mul7x6_fin", 64'(finish), 64'(1));
    chk("mul7x6_res", 64'(res), 64'h2A);
    chk("mul7x6_tag", 64'(tag_out), 64'(3));
    step();
    chk("mul7x6_retired", 64'(finish), 64'(0));

    // Mode / extension vectors
    run_one("mulh_m1x2",   2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 4'd1, 32'hFFFF_FFFF);
    run_one("mulhu_m1x2",  2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 4'd2, 32'h0000_0001);
    run_one("mulhsu_m1x2", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 4'd3, 32'hFFFF_FFFF);
    run_one("mul_m1x2",    2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 4'd4, 32'hFFFF_FFFE);
    run_one("mulhsu_2xm1", 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 4'd5, 32'h0000_0001);
    run_one("mulhu_maxsq", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'hFFFF_FFFE);
    run_one("mulh_m1sq",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'h0000_0000);
    run_one("mul_m1sq",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 32'h0000_0001);

    // Four back-to-back issues, tags 1..4, results i*(i+10)
    for (int i = 1; i <= 4; i++) issue(2'b00, 32'(i), 32'(i + 10), 4'(i));
    repeat (3) step();
    for (int i = 1; i <= 4; i++) begin
      $display("[TB] b2b slot %0d finish=%0d tag_out=%0d res=%h", i, finish, tag_out, res);
      chk($sformatf("b2b%0d_fin", i), 64'(finish), 64'(1));
      chk($sformatf("b2b%0d_tag", i), 64'(tag_out), 64'(i));
      chk($sformatf("b2b%0d_res", i), 64'(res), 64'(i * (i + 10)));
      step();
    end
    chk("b2b_done", 64'(finish), 64'(0));

    // Stall: three in flight, res_ack low for 5 cycles after first finish
    res_ack = 1'b0;
    for (int i = 0; i < 3; i++) issue(2'b00, 32'(i + 2), 32'd100, 4'(5 + i));
    repeat (4) step();
    for (int c = 0; c < 5; c++) begin
      $display("[TB] stall cycle %0d finish=%0d ready=%0d tag_out=%0d res=%h",
               c, finish, ready, tag_out, res);
      chk($sformatf("stall%0d_fin", c), 64'(finish), 64'(1));
      chk($sformatf("stall%0d_ready", c), 64'(ready), 64'(0));
      chk($sformatf("stall%0d_tag", c), 64'(tag_out), 64'(5));
      chk($sformatf("stall%0d_res", c), 64'(res), 64'(200));
      EN = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9; tag_in = 4'd9;  // must be ignored
      step();
      EN = 1'b0;
    end
    res_ack = 1'b1;
    chk("stall_rel_tag5", 64'(tag_out), 64'(5));
    step();
    $display("[TB] release 1 finish=%0d tag_out=%0d res=%h", finish, tag_out, res);
    chk("stall_rel_fin6", 64'(finish), 64'(1));
    chk("stall_rel_tag6", 64'(tag_out), 64'(6));
    chk("stall_rel_res6", 64'(res), 64'(300));
    step();
    $display("[TB] release 2 finish=%0d tag_out=%0d res=%h", finish, tag_out, res);
    chk("stall_rel_fin7", 64'(finish), 64'(1));
    chk("stall_rel_tag7", 64'(tag_out), 64'(7));
    chk("stall_rel_res7", 64'(res), 64'(400));
    nfin = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (finish === 1'b1) nfin++;
    end
    chk("stall_no_extra", 64'(nfin), 64'(0));

    // Flush: two in flight, flush with EN of a third, then a fresh op
    issue(2'b00, 32'd3, 32'd3, 4'd1);
    issue(2'b00, 32'd4, 32'd4, 4'd2);
    flush = 1'b1;
    issue(2'b00, 32'd5, 32'd5, 4'd3);
    flush = 1'b0;
    run_one("post_flush", 2'b00, 32'd11, 32'd13, 4'd4, 32'd143);
    nfin = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (finish === 1'b1) nfin++;
    end
    chk("flush_no_extra", 64'(nfin), 64'(0));

    // Reset mid-operation
    issue(2'b00, 32'd7, 32'd6, 4'd5);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("[TB] mid-op reset finish=%0d ready=%0d res=%h tag_out=%0d", finish, ready, res, tag_out);
    chk("mrst_res", 64'(res), 64'(0));
    chk("mrst_tag", 64'(tag_out), 64'(0));
    chk("mrst_ready", 64'(ready), 64'(1));
    nfin = 0;
    for (int c = 0; c < 12; c++) begin
      if (finish === 1'b1) nfin++;
      step();
    end
    chk("mrst_no_finish", 64'(nfin), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_mul_pipe.md
FU_MUL_PIPE -- requirements
Module: fu_mul_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter LATENCY, default 7, cycles from accept to finish; legal range 2..16.
REQ-003 Parameter TAG_W, default 4, width of the destination tag carried with each op.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port EN  input  1  issue request; op accepted when EN & ready at a rising edge.
REQ-007 Port op  input  2  mode: 00 MUL (low), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
REQ-008 Port A, B  input  WIDTH each  operands (A is rs1, B is rs2).
REQ-009 Port tag_in  input  TAG_W  destination tag of the issued op.
REQ-010 Port flush  input  1  discard all in-flight ops.
REQ-011 Port res_ack  input  1  consumer accepts the presented result.
REQ-012 Port ready  output  1  unit can accept an op this cycle.
REQ-013 Port finish  output  1  res/tag_out valid.
REQ-014 Port res  output  WIDTH  selected half of the 2*WIDTH product.
REQ-015 Port tag_out  output  TAG_W  tag matching res.

Function
REQ-016 Fully pipelined: one op accepted per cycle, up to LATENCY ops in flight.
REQ-017 Op accepted at edge t with no stall drives finish=1 in the cycle after edge t+LATENCY-1.
REQ-018 Product computed at 2*WIDTH bits; operands extended per op: MUL/MULHU zero-extend both, MULH sign-extend both, MULHSU sign-extend A and zero-extend B.
REQ-019 res = product[WIDTH-1:0] for MUL, product[2*WIDTH-1:WIDTH] for all other modes.
REQ-020 Stall = finish & ~res_ack; ready = ~stall.
REQ-021 While stall is high, every pipeline stage, finish, res and tag_out hold; EN is ignored.
REQ-022 Result retires at the edge where finish & res_ack; the next stage advances into the output in the same edge (no bubble).
REQ-023 A valid bit travels with each op; finish is the valid bit of the last stage; stages with valid=0 leave res/tag_out unchanged.
REQ-024 flush clears all valid bits at the next edge, including an op presented with EN in the same cycle; flush overrides stall.
REQ-025 res_ack while finish=0 has no effect.
REQ-026 tag_out is bit-identical to the tag_in of the op producing res; ops retire strictly in issue order.

Reset
REQ-027 rst=1 at an edge clears all valid bits, finish=0, res=0, tag_out=0; ready=1 from the following cycle.
REQ-028 rst mid-operation discards all in-flight ops; no finish is produced for them.
REQ-029 rst has priority over flush, EN and res_ack.

Structure
REQ-030 Shared package fu_mul_pkg holds op encoding constants (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU) and default WIDTH/TAG_W/LATENCY.
REQ-031 One sub-module, mul_core: (WIDTH+1)×(WIDTH+1) signed multiplier with LATENCY-1 register stages and a shared enable driven by ~stall.
REQ-032 fu_mul_pipe holds the valid/tag/op shift registers, stall logic and result half-select.

Verification
REQ-033 WIDTH=32, LATENCY=7: EN with op=MUL, A=0x0000_0007, B=0x0000_0006, tag=3, res_ack tied 1 -> finish 7 cycles later, res=0x0000_002A, tag_out=3.
REQ-034 A=0xFFFF_FFFF, B=0x0000_0002: MULH -> 0xFFFF_FFFF; MULHU -> 0x0000_0001; MULHSU -> 0xFFFF_FFFF; MUL -> 0xFFFF_FFFE.
REQ-035 Four back-to-back issues, tags 1..4, res_ack=1 -> finish high four consecutive cycles, tags 1,2,3,4 in order.
REQ-036 Three ops in flight, res_ack=0 for 5 cycles after first finish -> res/tag_out frozen, ready=0; then res_ack=1 -> remaining two results on next two cycles, none lost or duplicated.
REQ-037 Two ops in flight, flush asserted together with EN of a third -> no finish for any of the three; a new op issued next cycle finishes after 7 cycles.
REQ-038 rst pulsed 3 cycles after an issue -> finish never asserted for that op, res=0, tag_out=0, ready=1.
